// File: rtl/main_decoder_if.sv
// Opcode-in / control-out bundle between the instruction fetch side and the
// main control decoder.
interface main_decoder_if;
    logic [6:0] Op;
    logic       Branch;
    logic       ResultSrc;
    logic       MemWrite;
    logic       ALUSrc;
    logic [1:0] ImmSrc;
    logic       RegWrite;
    logic [1:0] ALUOp;
    logic       Illegal;

    modport master (
        output Op,
        input  Branch, ResultSrc, MemWrite, ALUSrc, ImmSrc, RegWrite, ALUOp, Illegal
    );

    modport slave (
        input  Op,
        output Branch, ResultSrc, MemWrite, ALUSrc, ImmSrc, RegWrite, ALUOp, Illegal
    );
endinterface

// File: rtl/main_decoder.sv
// RV32I main control decoder: opcode -> datapath controls, registered once.
// Define MAIN_DECODER_ITYPE_EN to also decode I-type ALU ops (0010011).
module main_decoder (
    input  logic           clk,
    input  logic           rst_n,
    main_decoder_if.slave  bus
);
    typedef struct packed {
        logic       reg_write;
        logic [1:0] imm_src;
        logic       alu_src;
        logic       mem_write;
        logic       result_src;
        logic       branch;
        logic [1:0] alu_op;
        logic       illegal;
    } ctrl_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
`ifdef MAIN_DECODER_ITYPE_EN
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
`endif

    ctrl_t ctrl_d;
    ctrl_t ctrl_q;

    // Unlisted (or X/Z) opcodes fall to the default row: no write is ever
    // enabled and Illegal flags the instruction.
    always_comb begin
        ctrl_d = '{reg_write: 1'b0, imm_src: 2'b00, alu_src: 1'b0,
                   mem_write: 1'b0, result_src: 1'b0, branch: 1'b0,
                   alu_op: 2'b00, illegal: 1'b1};
        case (bus.Op)
            OP_LW: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.alu_src    = 1'b1;
                ctrl_d.result_src = 1'b1;
                ctrl_d.illegal    = 1'b0;
            end
            OP_SW: begin
                ctrl_d.imm_src    = 2'b01;
                ctrl_d.alu_src    = 1'b1;
                ctrl_d.mem_write  = 1'b1;
                ctrl_d.illegal    = 1'b0;
            end
            OP_RTYPE: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.alu_op     = 2'b10;
                ctrl_d.illegal    = 1'b0;
            end
            OP_BEQ: begin
                ctrl_d.imm_src    = 2'b10;
                ctrl_d.branch     = 1'b1;
                ctrl_d.alu_op     = 2'b01;
                ctrl_d.illegal    = 1'b0;
            end
`ifdef MAIN_DECODER_ITYPE_EN
            OP_ITYPE: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.alu_src    = 1'b1;
                ctrl_d.alu_op     = 2'b10;
                ctrl_d.illegal    = 1'b0;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign bus.RegWrite  = ctrl_q.reg_write;
    assign bus.ImmSrc    = ctrl_q.imm_src;
    assign bus.ALUSrc    = ctrl_q.alu_src;
    assign bus.MemWrite  = ctrl_q.mem_write;
    assign bus.ResultSrc = ctrl_q.result_src;
    assign bus.Branch    = ctrl_q.branch;
    assign bus.ALUOp     = ctrl_q.alu_op;
    assign bus.Illegal   = ctrl_q.illegal;
endmodule

// File: tb/tb_main_decoder.sv
// Directed bench for main_decoder; control word packed as
// {RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUOp, Illegal}.
module tb_main_decoder;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    main_decoder_if bus ();

    main_decoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [10:0] W_ZERO = 11'b0_00_0_0_0_0_00_0;
    localparam logic [10:0] W_LW   = 11'b1_00_1_0_1_0_00_0;
    localparam logic [10:0] W_SW   = 11'b0_01_1_1_0_0_00_0;
    localparam logic [10:0] W_R    = 11'b1_00_0_0_0_0_10_0;
    localparam logic [10:0] W_BEQ  = 11'b0_10_0_0_0_1_01_0;
    localparam logic [10:0] W_ILL  = 11'b0_00_0_0_0_0_00_1;
    localparam logic [10:0] W_ITY  = 11'b1_00_1_0_0_0_10_0;

    function automatic logic [10:0] observed();
        return {bus.RegWrite, bus.ImmSrc, bus.ALUSrc, bus.MemWrite,
                bus.ResultSrc, bus.Branch, bus.ALUOp, bus.Illegal};
    endfunction

    function automatic logic [10:0] table_row(input logic [6:0] op);
        case (op)
            7'b0000011: return W_LW;
            7'b0100011: return W_SW;
            7'b0110011: return W_R;
            7'b1100011: return W_BEQ;
`ifdef MAIN_DECODER_ITYPE_EN
            7'b0010011: return W_ITY;
`endif
            default:    return W_ILL;
        endcase
    endfunction

    task automatic check(input string tag, input logic [10:0] exp);
        logic [10:0] got;
        got = observed();
        vectors++;
        assert (got === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    // Apply inputs, take one rising edge, sample 1 time unit later.
    task automatic step(input logic [6:0] op, input logic rn);
        bus.Op = op;
        rst_n  = rn;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int order [128];
        vectors     = 0;
        miscompares = 0;
        bus.Op      = 7'b0110011;
        rst_n       = 1'b0;
        @(negedge clk);

        step(7'b0110011, 1'b0); check("reset_edge1", W_ZERO);
        step(7'b0110011, 1'b0); check("reset_edge2", W_ZERO);
        step(7'b0110011, 1'b1); check("release_rtype", W_R);

        step(7'b0000000, 1'b1); check("seq_nop", W_ILL);
        step(7'b0000011, 1'b1); check("seq_lw", W_LW);
        step(7'b0100011, 1'b1); check("seq_sw", W_SW);
        step(7'b0110011, 1'b1); check("seq_rtype", W_R);
        step(7'b1100011, 1'b1); check("seq_beq", W_BEQ);

        step(7'b0010011, 1'b1);
`ifdef MAIN_DECODER_ITYPE_EN
        check("itype_on", W_ITY);
`else
        check("itype_off", W_ILL);
`endif

        step(7'b1100011, 1'b1); check("beq_hold", W_BEQ);
        step(7'b1100011, 1'b0); check("midreset_beq", W_ZERO);
        step(7'b1100011, 1'b1); check("midrelease_beq", W_BEQ);
        step(7'b1111111, 1'b1); check("op_all_ones", W_ILL);
        step(7'b0000011, 1'b1); check("lw_after_ill", W_LW);

        for (int i = 0; i < 128; i++) order[i] = i;
        for (int i = 127; i > 0; i--) begin
            int j;
            int t;
            j        = $urandom_range(i, 0);
            t        = order[i];
            order[i] = order[j];
            order[j] = t;
        end
        for (int i = 0; i < 128; i++) begin
            logic [6:0] op;
            op = order[i][6:0];
            step(op, 1'b1);
            check($sformatf("sweep_op_%b", op), table_row(op));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
